// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs upstream instruction fields into 32-bit words and queues them in a
//   small FIFO for an instruction-memory writer. A read-after-write hazard
//   against the previously queued instruction inserts one NOP bubble word
//   ahead of the dependent instruction. out_addr counts words handed to the
//   consumer since the program started.
//
// Ports
//   clock, reset_n        single clock, synchronous active-low reset
//   start                 one-cycle pulse that begins a program (IDLE/DONE)
//   in_valid / in_ready   upstream handshake for in_* fields
//   in_alu_ctrl, in_write_addr, in_r1_addr, in_r2_addr, in_last
//   out_valid / out_ready downstream handshake for out_instr / out_addr
//   count                 FIFO occupancy
//   done                  program fully drained
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | accepting instructions
// BUBBLE | hazard seen, queue one NOP word before the held instruction
// DRAIN  | last instruction accepted, waiting for FIFO to empty
// DONE   | program drained, start begins another
module instr_encoder #(
    parameter int         DEPTH    = 8,
    parameter logic [3:0] NOP_CTRL = 4'hF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_alu_ctrl,
    input  logic [7:0]               in_write_addr,
    input  logic [7:0]               in_r1_addr,
    input  logic [7:0]               in_r2_addr,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [15:0]              out_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_BUBBLE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     out_addr_q, out_addr_d;
    logic            prev_valid_q, prev_valid_d;
    logic [7:0]      prev_wr_q, prev_wr_d;
    logic [31:0]     mem_q [DEPTH];

    logic            not_full;
    logic            hazard;
    logic            accept;
    logic            bubble_push;
    logic            push;
    logic            pop;
    logic            enter_run;
    logic [31:0]     push_word;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_addr_q   <= '0;
            prev_valid_q <= 1'b0;
            prev_wr_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_addr_q   <= out_addr_d;
            prev_valid_q <= prev_valid_d;
            prev_wr_q    <= prev_wr_d;
        end
    end

    // Storage needs no reset: out_instr is masked whenever count is 0.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (accept && in_last)         state_d = S_DRAIN;
                else if (hazard && not_full)   state_d = S_BUBBLE;
            end
            S_BUBBLE: if (not_full) state_d = S_RUN;
            S_DRAIN:  if (count_q == '0) state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        not_full    = (count_q < DEPTH_C);
        hazard      = in_valid && prev_valid_q &&
                      ((in_r1_addr == prev_wr_q) || (in_r2_addr == prev_wr_q));
        in_ready    = (state_q == S_RUN) && not_full && !hazard;
        accept      = in_valid && in_ready;
        bubble_push = (state_q == S_BUBBLE) && not_full;
        push        = accept || bubble_push;
        push_word   = bubble_push ? {4'b0, NOP_CTRL, 24'h0}
                                  : {4'b0, in_alu_ctrl, in_write_addr, in_r1_addr, in_r2_addr};
        out_valid   = (count_q != '0);
        pop         = out_valid && out_ready;
        out_instr   = out_valid ? mem_q[rd_ptr_q] : 32'h0;
        out_addr    = out_addr_q;
        count       = count_q;
        done        = (state_q == S_DONE);
        enter_run   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        // Entering RUN only happens with an empty FIFO, so no pop competes.
        out_addr_d = out_addr_q;
        if (enter_run) out_addr_d = 16'h0;
        else if (pop)  out_addr_d = out_addr_q + 16'd1;

        // A NOP (upstream or bubble) writes nothing, so it cannot cause a hazard.
        prev_valid_d = prev_valid_q;
        prev_wr_d    = prev_wr_q;
        if (enter_run) begin
            prev_valid_d = 1'b0;
        end else if (accept) begin
            prev_valid_d = (in_alu_ctrl != NOP_CTRL);
            prev_wr_d    = in_write_addr;
        end else if (bubble_push) begin
            prev_valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int         DEPTH = 8;
    localparam logic [3:0] NOP   = 4'hF;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_alu_ctrl = '0;
    logic [7:0]  in_write_addr = '0;
    logic [7:0]  in_r1_addr = '0;
    logic [7:0]  in_r2_addr = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [15:0] out_addr;
    logic [$clog2(DEPTH):0] count;
    logic        done;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] w;
        logic [7:0] r1;
        logic [7:0] r2;
        logic       last;
    } instr_t;

    typedef struct packed {
        logic [31:0] word;
        logic [15:0] addr;
    } exp_t;

    exp_t   exp_q[$];
    instr_t prog_q[$];
    exp_t   mon_e;
    int     n_cmp = 0;
    int     n_err = 0;
    int     ready_mode = 2;   // 0 random, 1 always ready, 2 never ready

    instr_encoder #(.DEPTH(DEPTH), .NOP_CTRL(NOP)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_ctrl(in_alu_ctrl), .in_write_addr(in_write_addr),
        .in_r1_addr(in_r1_addr), .in_r2_addr(in_r2_addr), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .count(count), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        case (ready_mode)
            0:       out_ready = ($urandom_range(0, 3) != 0);
            1:       out_ready = 1'b1;
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: every word the consumer takes is checked against the queue.
    always @(negedge clock) begin
        #2;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %h expected none", out_instr);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_instr", out_instr, mon_e.word);
                check("out_addr", 32'(out_addr), 32'(mon_e.addr));
            end
        end else if (reset_n && !out_valid) begin
            check("empty_out_instr", out_instr, 32'h0);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic instr_t mk(input logic [3:0] a, input logic [7:0] w,
                                  input logic [7:0] r1, input logic [7:0] r2, input logic last);
        instr_t x;
        x.a = a; x.w = w; x.r1 = r1; x.r2 = r2; x.last = last;
        return x;
    endfunction

    // Reference: program order stream; a read of the last real write target
    // gets a NOP word in front of it. Addresses count from 0 per program.
    task automatic model_push();
        logic        pv = 1'b0;
        logic [7:0]  pw = '0;
        int          addr = 0;
        foreach (prog_q[i]) begin
            if (pv && (prog_q[i].r1 == pw || prog_q[i].r2 == pw)) begin
                exp_q.push_back({4'h0, NOP, 24'h0, addr[15:0]});
                addr++;
            end
            exp_q.push_back({4'h0, prog_q[i].a, prog_q[i].w, prog_q[i].r1, prog_q[i].r2, addr[15:0]});
            addr++;
            pv = (prog_q[i].a != NOP);
            pw = prog_q[i].w;
        end
    endtask

    task automatic send(input instr_t x);
        int guard = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_alu_ctrl = x.a; in_write_addr = x.w;
        in_r1_addr = x.r1; in_r2_addr = x.r2; in_last = x.last;
        #1;
        while (!in_ready && guard < 2000) begin
            @(negedge clock);
            #1;
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end else begin
            @(posedge clock);
        end
    endtask

    task automatic go_idle();
        @(negedge clock);
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic start_prog();
        @(negedge clock);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        check("done_after_start", 32'(done), 32'h0);
        check("ready_after_start", 32'(in_ready), 32'h1);
    endtask

    task automatic wait_done(input int bound);
        int g = 0;
        while (!done && g < bound) begin
            @(negedge clock);
            #1;
            g++;
        end
        check("done", 32'(done), 32'h1);
        check("drained", 32'(exp_q.size()), 32'h0);
        check("count_at_done", 32'(count), 32'h0);
    endtask

    task automatic send_all(input int gap);
        foreach (prog_q[i]) begin
            repeat ($urandom_range(0, gap)) go_idle();
            send(prog_q[i]);
        end
        go_idle();
    endtask

    task automatic random_program();
        int len = $urandom_range(1, 20);
        prog_q.delete();
        for (int i = 0; i < len; i++) begin
            prog_q.push_back(mk(($urandom_range(0, 4) == 0) ? NOP : 4'($urandom_range(0, 14)),
                                8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                                8'($urandom_range(0, 7)), (i == len - 1)));
        end
        model_push();
        start_prog();
        send_all(3);
        wait_done(500);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check("rst_count", 32'(count), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", 32'(out_addr), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset_n = 1'b1;

        // Single word, one-cycle latency
        ready_mode = 1;
        prog_q.delete();
        prog_q.push_back(mk(4'h3, 8'h05, 8'h01, 8'h02, 1'b1));
        model_push();
        start_prog();
        send(prog_q[0]);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("lat_out_valid", 32'(out_valid), 32'h1);
        check("lat_out_instr", out_instr, 32'h03050102);
        check("lat_out_addr", 32'(out_addr), 32'h0);
        wait_done(50);

        // Hazard produces a bubble between dependent words
        prog_q.delete();
        prog_q.push_back(mk(4'h1, 8'h07, 8'h00, 8'h00, 1'b0));
        prog_q.push_back(mk(4'h2, 8'h09, 8'h07, 8'h03, 1'b1));
        model_push();
        start_prog();
        send_all(0);
        wait_done(50);

        // Fill to full, then a single pop reopens in_ready
        ready_mode = 2;
        prog_q.delete();
        for (int i = 0; i < 10; i++)
            prog_q.push_back(mk(4'h4, 8'(8'h80 + i), 8'(8'h10 + i), 8'(8'h20 + i), (i == 9)));
        model_push();
        start_prog();
        for (int i = 0; i < 8; i++) send(prog_q[i]);
        @(negedge clock);
        in_valid = 1'b1;
        in_alu_ctrl = prog_q[8].a; in_write_addr = prog_q[8].w;
        in_r1_addr = prog_q[8].r1; in_r2_addr = prog_q[8].r2; in_last = 1'b0;
        #1;
        check("full_count", 32'(count), 32'd8);
        check("full_in_ready", 32'(in_ready), 32'h0);
        ready_mode = 1;
        @(negedge clock);
        #1;
        ready_mode = 2;
        @(negedge clock);
        #1;
        check("after_pop_count", 32'(count), 32'd7);
        check("after_pop_in_ready", 32'(in_ready), 32'h1);
        @(posedge clock);
        ready_mode = 0;
        send(prog_q[9]);
        go_idle();
        wait_done(500);

        // Randomized programs, restarted from DONE
        for (int p = 0; p < 12; p++) random_program();

        // Reset mid-program flushes buffered words
        ready_mode = 2;
        @(negedge clock);
        start_prog();
        for (int i = 0; i < 5; i++) send(mk(4'h5, 8'(8'h90 + i), 8'h11, 8'h22, 1'b0));
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("pre_rst_count", 32'(count), 32'd5);
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        check("mid_rst_count", 32'(count), 32'h0);
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check("mid_rst_out_instr", out_instr, 32'h0);
        check("mid_rst_in_ready", 32'(in_ready), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        reset_n = 1'b1;
        ready_mode = 0;
        in_valid = 1'b1;
        in_alu_ctrl = 4'h1; in_write_addr = 8'hA0; in_r1_addr = 8'h01; in_r2_addr = 8'h02;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            check("idle_in_ready", 32'(in_ready), 32'h0);
            check("idle_count", 32'(count), 32'h0);
        end
        go_idle();
        random_program();

        // out_addr wraps after 65536 pops
        ready_mode = 1;
        prog_q.delete();
        for (int i = 0; i < 65538; i++)
            prog_q.push_back(mk(4'h1, 8'h80, 8'h01, 8'h02, (i == 65537)));
        model_push();
        start_prog();
        send_all(0);
        wait_done(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001: Parameter DEPTH, default 8, SHALL set the instruction FIFO depth in words (power of two).
REQ-002: Parameter NOP_CTRL, default 4'hF, SHALL set the alu_ctrl value used for inserted bubbles.
REQ-003: clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: reset_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005: start  input  1  SHALL be a one-cycle pulse that begins a program.
REQ-006: in_valid  input  1  SHALL indicate the upstream instruction fields are valid.
REQ-007: in_ready  output  1  SHALL indicate the block accepts the fields this cycle.
REQ-008: in_alu_ctrl  input  4 / in_write_addr  input  8 / in_r1_addr  input  8 / in_r2_addr  input  8  SHALL be the instruction fields.
REQ-009: in_last  input  1  SHALL mark the final instruction of the program.
REQ-010: out_valid  output  1  SHALL indicate out_instr holds a word.
REQ-011: out_ready  input  1  SHALL indicate the consumer takes out_instr this cycle.
REQ-012: out_instr  output  32  SHALL be the encoded word at the FIFO head.
REQ-013: out_addr  output  16  SHALL be the instruction-memory index of out_instr.
REQ-014: count  output  $clog2(DEPTH)+1  SHALL be FIFO occupancy.
REQ-015: done  output  1  SHALL indicate the program has fully drained.

Function
REQ-016: Encoding SHALL be [31:28]=4'b0, [27:24]=alu_ctrl, [23:16]=write_addr, [15:8]=r1_addr, [7:0]=r2_addr.
REQ-017: FSM states SHALL be IDLE, RUN, BUBBLE, DRAIN, DONE.
REQ-018: IDLE->RUN on start; DONE->RUN on start; start in RUN/BUBBLE/DRAIN ignored.
REQ-019: Entering RUN SHALL clear out_addr to 0, prev_valid to 0, done to 0.
REQ-020: in_ready SHALL equal (state==RUN) && (count<DEPTH) && !hazard; no combinational path from out_ready.
REQ-021: hazard SHALL be in_valid && prev_valid && (in_r1_addr==prev_wr || in_r2_addr==prev_wr).
REQ-022: Accept (in_valid && in_ready) SHALL push the encoded word; prev_wr<=in_write_addr; prev_valid<=(in_alu_ctrl!=NOP_CTRL).
REQ-023: In RUN with hazard and count<DEPTH, state SHALL go to BUBBLE without accepting.
REQ-024: BUBBLE SHALL push one word {4'b0,NOP_CTRL,24'h0} when count<DEPTH (else wait), clear prev_valid, return to RUN; the held instruction is accepted no earlier than the next cycle.
REQ-025: Accepting a word with in_last=1 SHALL move RUN->DRAIN; in_ready SHALL be 0 in DRAIN.
REQ-026: DRAIN->DONE when count==0; done SHALL be 1 in DONE only.
REQ-027: Pop (out_valid && out_ready) SHALL advance head and increment out_addr modulo 2^16 (65535->0).
REQ-028: out_valid SHALL be (count!=0); out_instr SHALL be 0 when count==0.
REQ-029: Push-to-out_valid latency SHALL be 1 cycle; no bypass of an empty FIFO.
REQ-030: Simultaneous push and pop SHALL leave count unchanged; allowed when full only as pop (push blocked by REQ-020).
REQ-031: FIFO pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.

Reset
REQ-032: reset_n=0 SHALL force state IDLE, count 0, pointers 0, out_addr 0, prev_valid 0, in_ready 0, out_valid 0, out_instr 0, done 0.
REQ-033: Reset mid-program SHALL flush the FIFO; buffered words are discarded and not presented.

Verification
REQ-034: start, one word alu 3/w 5/r1 1/r2 2, last=1, out_ready=1 -> out_instr=32'h03050102 at out_addr 0 one cycle after accept; done=1 once count==0.
REQ-035: Word w=7 then word r1=7 -> bubble 32'h0F000000 emitted between them; out_addr 0,1,2.
REQ-036: out_ready=0, push 8 words -> count=8, in_ready=0; assert out_ready one cycle -> count 7, in_ready 1.
REQ-037: 65536 pops with out_ready=1 -> out_addr wraps 65535->0.
REQ-038: reset_n=0 with count=5 in RUN -> next cycle count 0, out_valid 0, state IDLE, start required to resume.
